// File: rtl/sent_pkg.sv
// Shared SENT CRC definitions: mode encodings, CRC polynomials/seeds and
// per-mode frame geometry used by both the TX generator and the RX checker.
package sent_pkg;

    localparam logic [2:0] MODE_FAST6 = 3'b001;
    localparam logic [2:0] MODE_FAST4 = 3'b010;
    localparam logic [2:0] MODE_FAST3 = 3'b011;
    localparam logic [2:0] MODE_SHORT = 3'b100;
    localparam logic [2:0] MODE_ENH   = 3'b101;

    localparam logic [4:0] POLY4 = 5'b11101;
    localparam logic [3:0] SEED4 = 4'b0101;
    localparam logic [6:0] POLY6 = 7'b1011001;
    localparam logic [5:0] SEED6 = 6'b010101;

    localparam int DW = 24;
    localparam int CW = 6;
    localparam int AW = 36;
    localparam int FW = 30;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } crc_state_e;

    function automatic logic mode_ok(input logic [2:0] m);
        return (m == MODE_FAST6) || (m == MODE_FAST4) || (m == MODE_FAST3)
            || (m == MODE_SHORT) || (m == MODE_ENH);
    endfunction

    function automatic logic is_crc6(input logic [2:0] m);
        return m == MODE_ENH;
    endfunction

    function automatic logic [5:0] data_len(input logic [2:0] m);
        logic [5:0] l;
        l = 6'd0;
        case (m)
            MODE_FAST6: l = 6'd24;
            MODE_FAST4: l = 6'd16;
            MODE_FAST3: l = 6'd12;
            MODE_SHORT: l = 6'd12;
            MODE_ENH:   l = 6'd24;
            default:    l = 6'd0;
        endcase
        return l;
    endfunction

    // Augmented length: seed + data + k zero bits.
    function automatic logic [5:0] aug_len(input logic [2:0] m);
        return data_len(m) + (is_crc6(m) ? 6'd12 : 6'd8);
    endfunction

    // Augmented word left-aligned so bit [AW-1] is always shifted first.
    function automatic logic [AW-1:0] aug_word(input logic [2:0] m,
                                               input logic [DW-1:0] d);
        logic [AW-1:0] a;
        a = '0;
        case (m)
            MODE_FAST6: a = {SEED4, d, 4'b0, 4'b0};
            MODE_FAST4: a = {SEED4, d[15:0], 4'b0, 12'b0};
            MODE_FAST3: a = {SEED4, d[11:0], 4'b0, 16'b0};
            MODE_SHORT: a = {SEED4, d[11:0], 4'b0, 16'b0};
            MODE_ENH:   a = {SEED6, d, 6'b0};
            default:    a = '0;
        endcase
        return a;
    endfunction

    function automatic logic [FW-1:0] frame_word(input logic [2:0] m,
                                                 input logic [DW-1:0] d,
                                                 input logic [CW-1:0] r);
        logic [FW-1:0] f;
        f = '0;
        case (m)
            MODE_FAST6: f = {2'b0, d, r[3:0]};
            MODE_FAST4: f = {10'b0, d[15:0], r[3:0]};
            MODE_FAST3: f = {14'b0, d[11:0], r[3:0]};
            MODE_SHORT: f = {14'b0, d[11:0], r[3:0]};
            MODE_ENH:   f = {d, r};
            default:    f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/sent_crc_lfsr_step.sv
// One bit of CRC long division; the k-wide datapath also runs 4-bit CRCs
// in its low bits, with the upper bits held at zero.
module sent_crc_lfsr_step #(
    parameter int K = 6
) (
    input  logic [K-1:0] rem,
    input  logic         din,
    input  logic [K-1:0] poly,
    input  logic         crc4,
    output logic [K-1:0] rem_nx
);

    logic         fb;
    logic [K-1:0] mask;
    logic [K-1:0] shifted;

    assign fb      = crc4 ? rem[3] : rem[K-1];
    assign mask    = crc4 ? {{(K-4){1'b0}}, 4'hF} : {K{1'b1}};
    assign shifted = {rem[K-2:0], din};
    assign rem_nx  = (shifted ^ (fb ? poly : '0)) & mask;

endmodule

// File: rtl/sent_tx_crc_gen.sv
// SENT transmit CRC generator: bit-serial seeded CRC4/CRC6 over the
// latched payload, returning the CRC and the RX-aligned frame word.
module sent_tx_crc_gen
    import sent_pkg::*;
(
    input  logic          clk_rx,
    input  logic          reset_n_rx,
    input  logic          crc_req,
    input  logic [2:0]    crc_mode,
    input  logic [DW-1:0] data_in,
    output logic          busy,
    output logic          crc_done,
    output logic [CW-1:0] crc_out,
    output logic [FW-1:0] frame_out,
    output logic          mode_err
);

    crc_state_e    state;
    crc_state_e    state_nx;

    logic [2:0]    mode_q;
    logic [DW-1:0] data_q;
    logic [AW-1:0] aug_q;
    logic [CW-1:0] rem_q;
    logic [5:0]    cnt_q;

    logic          accept;
    logic          reject;
    logic [CW-1:0] poly_sel;
    logic [CW-1:0] rem_nx;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        reject   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (crc_req) begin
                    if (mode_ok(crc_mode)) begin
                        accept   = 1'b1;
                        state_nx = ST_LOAD;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_LOAD:  state_nx = ST_SHIFT;
            ST_SHIFT: if (cnt_q == 6'd1) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    assign poly_sel = is_crc6(mode_q) ? POLY6[CW-1:0] : {2'b00, POLY4[3:0]};

    sent_crc_lfsr_step #(
        .K(CW)
    ) u_step (
        .rem    (rem_q),
        .din    (aug_q[AW-1]),
        .poly   (poly_sel),
        .crc4   (!is_crc6(mode_q)),
        .rem_nx (rem_nx)
    );

    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            mode_q    <= '0;
            data_q    <= '0;
            aug_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            crc_done  <= 1'b0;
            crc_out   <= '0;
            frame_out <= '0;
            mode_err  <= 1'b0;
        end else begin
            mode_err <= reject;
            crc_done <= 1'b0;
            if (accept) begin
                mode_q <= crc_mode;
                data_q <= data_in;
                busy   <= 1'b1;
            end
            case (state)
                ST_LOAD: begin
                    aug_q <= aug_word(mode_q, data_q);
                    rem_q <= '0;
                    cnt_q <= aug_len(mode_q);
                end
                ST_SHIFT: begin
                    aug_q <= {aug_q[AW-2:0], 1'b0};
                    rem_q <= rem_nx;
                    cnt_q <= cnt_q - 6'd1;
                end
                ST_DONE: begin
                    crc_out   <= rem_q;
                    frame_out <= frame_word(mode_q, data_q, rem_q);
                    crc_done  <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
